// File: rtl/mpeg_avalon_pkg.sv
// -----------------------------------------------------------------------------
// mpeg_avalon_pkg
// Shared definitions for the byte-wide Avalon-MM link between the motion
// estimator master and its reference-frame slave.
//   AV_ADDR_W / AV_DATA_W : Avalon address and data widths
//   REF_FRAME_BASE        : default Avalon byte address of the reference window
//   px_t                  : one pixel byte
//   sat_inc16             : saturating 16-bit increment for statistics counters
// -----------------------------------------------------------------------------
package mpeg_avalon_pkg;

   localparam int AV_ADDR_W = 32;
   localparam int AV_DATA_W = 8;

   // Same constant is used when the motion estimator is instantiated.
   localparam logic [AV_ADDR_W-1:0] REF_FRAME_BASE = 32'd12345678;

   typedef logic [AV_DATA_W-1:0] px_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ref_rd_pipe.sv
// -----------------------------------------------------------------------------
// ref_rd_pipe
// Fixed-depth read-response pipeline of {valid, data}. A response entering
// stage 0 appears on the outputs RD_LAT cycles later. Data registers only
// load when the stage feeding them is valid, so the output byte holds its
// last delivered value while out_valid is low.
//   clk, rst   : clock, synchronous active-high clear (flushes all stages)
//   in_valid   : accepted read this cycle
//   in_data    : byte sampled for that read
//   out_valid  : final-stage valid (readdatavalid)
//   out_data   : final-stage data (readdata)
// -----------------------------------------------------------------------------
module ref_rd_pipe
   import mpeg_avalon_pkg::*;
#(
   parameter int RD_LAT = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [AV_DATA_W-1:0] in_data,
   output logic                 out_valid,
   output logic [AV_DATA_W-1:0] out_data
);

   logic [RD_LAT-1:0] valid_r;
   px_t               data_r [RD_LAT];

   // Shift valid every cycle; move data only behind a valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            data_r[i] <= 8'h00;
         end
      end else begin
         valid_r[0] <= in_valid;
         if (in_valid) begin
            data_r[0] <= in_data;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            valid_r[i] <= valid_r[i-1];
            if (valid_r[i-1]) begin
               data_r[i] <= data_r[i-1];
            end
         end
      end
   end

   assign out_valid = valid_r[RD_LAT-1];
   assign out_data  = data_r[RD_LAT-1];

endmodule

// File: rtl/ref_frame_slave.sv
// -----------------------------------------------------------------------------
// ref_frame_slave
// Avalon-MM pipelined slave holding one reference-frame window in on-chip
// byte memory. A local fill port from the capture path writes with priority;
// any Avalon request colliding with a fill is stalled via waitrequest.
// Reads are fully pipelined with a fixed latency of RD_LAT cycles.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   read, write, addr,
//   writedata                 : Avalon request
//   readdata, readdatavalid   : Avalon read response (registered)
//   waitrequest               : combinational stall, (read|write) & lwren
//   lwren, laddr, ldata       : local fill write port
//   rd_cnt, wr_cnt, stall_cnt : saturating statistics, only present when
//                               REF_FRAME_SLAVE_STATS_EN is defined
// -----------------------------------------------------------------------------
module ref_frame_slave
   import mpeg_avalon_pkg::*;
#(
   parameter int                    ADDR_W   = 12,
   parameter logic [AV_ADDR_W-1:0]  BASE     = REF_FRAME_BASE,
   parameter int                    RD_LAT   = 2,
   parameter logic [AV_DATA_W-1:0]  OOR_DATA = 8'h00
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 read,
   input  logic                 write,
   input  logic [AV_ADDR_W-1:0] addr,
   input  logic [AV_DATA_W-1:0] writedata,
   output logic [AV_DATA_W-1:0] readdata,
   output logic                 readdatavalid,
   output logic                 waitrequest,
   input  logic                 lwren,
   input  logic [ADDR_W-1:0]    laddr,
   input  logic [AV_DATA_W-1:0] ldata
`ifdef REF_FRAME_SLAVE_STATS_EN
   ,
   output logic [15:0]          rd_cnt,
   output logic [15:0]          wr_cnt,
   output logic [15:0]          stall_cnt
`endif
);

   localparam int DEPTH = 2**ADDR_W;

   px_t                  mem_r [DEPTH];
   logic [AV_ADDR_W-1:0] off_s;
   logic                 in_range_s;
   logic                 wait_s;
   logic                 rd_acc_s;
   logic                 wr_acc_s;
   px_t                  rd_data_s;

   // Address decode, stall and acceptance. A simultaneous read+write is a
   // protocol violation: the write wins and the read is dropped.
   always_comb begin
      off_s      = addr - BASE;
      in_range_s = (addr >= BASE) && (off_s[AV_ADDR_W-1:ADDR_W] == '0);
      wait_s     = (read | write) & lwren;
      wr_acc_s   = write & ~wait_s;
      rd_acc_s   = read & ~write & ~wait_s;
      if (in_range_s) begin
         rd_data_s = mem_r[off_s[ADDR_W-1:0]];
      end else begin
         rd_data_s = OOR_DATA;
      end
   end

   assign waitrequest = wait_s;

   // Byte memory; fill port first (Avalon is stalled whenever lwren is high).
   // Contents survive reset.
   always_ff @(posedge clk) begin
      if (lwren) begin
         mem_r[laddr] <= ldata;
      end else if (wr_acc_s && in_range_s) begin
         mem_r[off_s[ADDR_W-1:0]] <= writedata;
      end
   end

   // Read data is captured at the acceptance edge, so a later fill to the
   // same byte cannot change an in-flight response.
   ref_rd_pipe #(
      .RD_LAT    (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_acc_s),
      .in_data   (rd_data_s),
      .out_valid (readdatavalid),
      .out_data  (readdata)
   );

`ifdef REF_FRAME_SLAVE_STATS_EN
   logic [15:0] rd_cnt_r;
   logic [15:0] wr_cnt_r;
   logic [15:0] stall_cnt_r;

   // Saturating traffic counters, out-of-range accesses included.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_r    <= 16'h0000;
         wr_cnt_r    <= 16'h0000;
         stall_cnt_r <= 16'h0000;
      end else begin
         if (rd_acc_s) begin
            rd_cnt_r <= sat_inc16(rd_cnt_r);
         end
         if (wr_acc_s) begin
            wr_cnt_r <= sat_inc16(wr_cnt_r);
         end
         if (wait_s) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
         end
      end
   end

   assign rd_cnt    = rd_cnt_r;
   assign wr_cnt    = wr_cnt_r;
   assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ref_frame_slave.sv
// -----------------------------------------------------------------------------
// tb_ref_frame_slave
// Self-checking bench for ref_frame_slave: directed vector table, hand-written
// reset/statistics sequences and a randomized phase, all compared against a
// behavioural model (byte array + queue of responses tagged with due cycle).
// Define REF_FRAME_SLAVE_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_ref_frame_slave;

   localparam int          ADDR_W = 12;
   localparam int          DEPTH  = 4096;
   localparam int          RD_LAT = 2;
   localparam logic [31:0] BASE   = 32'd12345678;

   logic        clk = 1'b0;
   logic        rst, read, write, lwren;
   logic [31:0] addr;
   logic [7:0]  writedata, ldata, readdata;
   logic [11:0] laddr;
   logic        readdatavalid, waitrequest;
`ifdef REF_FRAME_SLAVE_STATS_EN
   logic [15:0] rd_cnt, wr_cnt, stall_cnt;
`endif

   always #5 clk = ~clk;

   ref_frame_slave #(
      .ADDR_W(ADDR_W), .BASE(BASE), .RD_LAT(RD_LAT), .OOR_DATA(8'h00)
   ) dut (
      .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
      .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
      .waitrequest(waitrequest), .lwren(lwren), .laddr(laddr), .ldata(ldata)
`ifdef REF_FRAME_SLAVE_STATS_EN
      , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct { int due; logic [7:0] d; } rsp_t;
   logic [7:0] mem_m [DEPTH];
   rsp_t       q_m[$];
   logic [7:0] last_m;
   int         cyc = 0;
   int         rdc_m = 0, wrc_m = 0, stc_m = 0;

   int checks = 0, errors = 0;
   logic       s_wait, s_v;
   logic [7:0] s_d;
   logic [15:0] s_rc, s_wc, s_sc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One bus cycle: drive, check at negedge, advance model at the posedge.
   task automatic step(input logic r, input logic w, input logic [31:0] a,
                       input logic [7:0] wd, input logic lw, input logic [11:0] la,
                       input logic [7:0] ld, input logic rs);
      bit     ev;
      bit     inr;
      longint al, bl;
      read = r; write = w; addr = a; writedata = wd;
      lwren = lw; laddr = la; ldata = ld; rst = rs;
      @(negedge clk);
      s_wait = waitrequest; s_v = readdatavalid; s_d = readdata;
      chk("waitrequest", 32'(s_wait), 32'((r | w) & lw));
      // Outputs during the reset cycle itself are not constrained.
      if (!rs) begin
         ev = (q_m.size() > 0) && (q_m[0].due == cyc);
         chk("readdatavalid", 32'(s_v), 32'(ev));
         if (ev) chk("readdata", 32'(s_d), 32'(q_m[0].d));
         else    chk("readdata_hold", 32'(s_d), 32'(last_m));
      end
`ifdef REF_FRAME_SLAVE_STATS_EN
      s_rc = rd_cnt; s_wc = wr_cnt; s_sc = stall_cnt;
      chk("rd_cnt", 32'(s_rc), 32'(rdc_m));
      chk("wr_cnt", 32'(s_wc), 32'(wrc_m));
      chk("stall_cnt", 32'(s_sc), 32'(stc_m));
`endif
      @(posedge clk);
      if (q_m.size() > 0 && q_m[0].due == cyc) begin
         last_m = q_m[0].d;
         void'(q_m.pop_front());
      end
      al  = longint'(a);
      bl  = longint'(BASE);
      inr = (al >= bl) && (al < bl + DEPTH);
      if (rs) begin
         q_m.delete();
         last_m = 8'h00;
         rdc_m = 0; wrc_m = 0; stc_m = 0;
      end else begin
         if ((r | w) & lw) stc_m = (stc_m < 65535) ? stc_m + 1 : stc_m;
         if (!lw && r && !w) begin
            rdc_m = (rdc_m < 65535) ? rdc_m + 1 : rdc_m;
            q_m.push_back('{due: cyc + RD_LAT, d: inr ? mem_m[int'(al - bl)] : 8'h00});
         end
         if (!lw && w) wrc_m = (wrc_m < 65535) ? wrc_m + 1 : wrc_m;
      end
      if (lw) mem_m[la] = ld;
      else if (w && inr) mem_m[int'(al - bl)] = wd;
      cyc++;
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic rd; logic wr; int off; logic [7:0] wd;
      logic lw; logic [11:0] la; logic [7:0] ld;
      logic ew; logic ev; logic [7:0] ed;
   } vec_t;
   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r, w, lw, rs, held;
      logic [31:0] a;
      logic [7:0]  wd, ld;
      logic [11:0] la;
      int          kind;

      //            rd    wr    off   wd     lw    la      ld     ew    ev    ed
      tbl.push_back(vec_t'{1'b0, 1'b1, 5,    8'hA7, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b1, 1'b0, 5,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'hA7});
      for (int i = 0; i < 4; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, i, 8'(8'h10 + i), 1'b0, 12'd0, 8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b1, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b1, 1'b0, 2,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h10});
      tbl.push_back(vec_t'{1'b1, 1'b0, 3,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h11});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h12});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h13});
      for (int i = 0; i < 3; i++)
         tbl.push_back(vec_t'{1'b1, 1'b0, 9, 8'h00, 1'b1, 12'd9,  8'h3C, 1'b1, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b1, 1'b0, 9,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h3C});
      tbl.push_back(vec_t'{1'b1, 1'b0, -1,   8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b1, 1'b0, 4096, 8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b1, 4096, 8'h55, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h00});
      tbl.push_back(vec_t'{1'b1, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h10});
      tbl.push_back(vec_t'{1'b1, 1'b1, 6,    8'h66, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b1, 1'b0, 6,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b0, 8'h00});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b0, 12'd0,  8'h00, 1'b0, 1'b1, 8'h66});
      tbl.push_back(vec_t'{1'b0, 1'b0, 0,    8'h00, 1'b1, 12'd20, 8'h77, 1'b0, 1'b0, 8'h00});

      read = 1'b0; write = 1'b0; addr = 32'h0; writedata = 8'h00;
      lwren = 1'b0; laddr = 12'h000; ldata = 8'h00; rst = 1'b1;
      @(posedge clk); #1;
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1);
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1);

      // Fill the whole window through the local port.
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 12'(i), 8'($urandom), 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rd, tbl[i].wr, BASE + 32'(tbl[i].off), tbl[i].wd,
              tbl[i].lw, tbl[i].la, tbl[i].ld, 1'b0);
         chk($sformatf("tbl%0d_wait", i), 32'(s_wait), 32'(tbl[i].ew));
         chk($sformatf("tbl%0d_valid", i), 32'(s_v), 32'(tbl[i].ev));
         if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(s_d), 32'(tbl[i].ed));
      end

      // Reset flushes in-flight reads but keeps memory.
      step(1'b1, 1'b0, BASE + 32'd1, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b1, 1'b0, BASE + 32'd2, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
         chk("rst_flush_valid", 32'(s_v), 32'h0);
         chk("rst_readdata", 32'(s_d), 32'h0);
      end
      step(1'b1, 1'b0, BASE + 32'd1, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      chk("mem_kept_valid", 32'(s_v), 32'h1);
      chk("mem_kept_data", 32'(s_d), 32'h11);

`ifdef REF_FRAME_SLAVE_STATS_EN
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, BASE + 32'd9, 8'h00, 1'b1, 12'd30, 8'h01, 1'b0);
      step(1'b1, 1'b0, BASE + 32'd9, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b1, 1'b0, BASE + 32'd0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b1, 1'b0, BASE + 32'd1, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b0, 1'b1, BASE + 32'd40, 8'hC1, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b0, 1'b1, BASE + 32'd41, 8'hC2, 1'b0, 12'h000, 8'h00, 1'b0);
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      chk("stats_rd", 32'(s_rc), 32'd3);
      chk("stats_wr", 32'(s_wc), 32'd2);
      chk("stats_stall", 32'(s_sc), 32'd4);
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1);
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0);
      chk("stats_rst", 32'({s_rc, s_wc} | 32'(s_sc)), 32'h0);
`endif

      // Randomized traffic; a stalled request is held until accepted.
      held = 1'b0;
      r = 1'b0; w = 1'b0; a = BASE; wd = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         if (!held) begin
            kind = $urandom_range(0, 19);
            r  = (kind < 8) || (kind == 19);
            w  = (kind >= 8 && kind < 14) || (kind == 19);
            wd = 8'($urandom);
            case ($urandom_range(0, 15))
               0:       a = BASE - 32'($urandom_range(1, 3));
               1:       a = BASE + 32'd4096 + 32'($urandom_range(0, 3));
               2:       a = $urandom;
               default: a = BASE + 32'($urandom_range(0, 31));
            endcase
         end
         lw = ($urandom_range(0, 3) == 0);
         la = 12'($urandom_range(0, 31));
         ld = 8'($urandom);
         rs = ($urandom_range(0, 299) == 0);
         step(r, w, a, wd, lw, la, ld, rs);
         held = (r | w) & lw & ~rs;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ref_frame_slave.md
Name: ref_frame_slave

Overview:
- Avalon-MM pipelined slave: the responder for the motion estimator's byte-wide Avalon master (read/write/addr/writedata/readdata/readdatavalid/waitrequest).
- Holds one reference-frame window in on-chip byte memory.
- A local fill port from the camera capture path writes pixels with priority over Avalon traffic; collisions are resolved by asserting waitrequest.
- Reads return after a fixed parameterised latency, fully pipelined: one accepted read per cycle.

Parameters:
- ADDR_W, 12: local byte-address width; DEPTH = 2**ADDR_W bytes.
- BASE, 32'd12345678: Avalon byte address of memory offset 0.
- RD_LAT, 2: cycles from read acceptance to readdatavalid; legal range 1..8.
- OOR_DATA, 8'h00: readdata returned for out-of-range reads.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- addr  in  32  Avalon byte address.
- writedata  in  8  Avalon write byte.
- readdata  out  8  Avalon read byte; valid only with readdatavalid.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- waitrequest  out  1  stall; the master must hold its request.
- lwren  in  1  local fill write strobe.
- laddr  in  ADDR_W  local fill byte offset.
- ldata  in  8  local fill byte.

Behaviour:
- Reset: synchronous, active-high on clk (rst). Reset values:
  - readdata=0, readdatavalid=0.
  - Read pipeline flushed: reads accepted before or during the rst cycle never produce readdatavalid.
  - Memory contents are NOT cleared.
- waitrequest: combinational, = (read|write) & lwren. It is 0 when no request is present.
- Acceptance: a request is accepted on a rising edge where (read|write) & ~waitrequest.
- Address decode:
  - off = addr - BASE (32-bit); in-range iff addr >= BASE and off < DEPTH.
  - Memory is indexed by off[ADDR_W-1:0].
- Accepted write:
  - In range: mem[off] <= writedata.
  - Out of range: silently dropped.
  - No response pulse.
- Accepted read:
  - Data is sampled at the acceptance edge: mem[off] if in range, else OOR_DATA.
  - The data enters a RD_LAT-deep valid/data shift pipeline.
  - readdata/readdatavalid are driven from the final stage, exactly RD_LAT cycles after acceptance.
  - Back-to-back accepted reads give back-to-back readdatavalid pulses, in order.
- Local fill: when lwren=1, mem[laddr] <= ldata on that edge, unconditionally. The concurrent Avalon request is stalled.
- Ordering:
  - A read accepted in the cycle after a write to the same offset returns the new byte.
  - A local write landing after a read's acceptance does not alter that read's data.
- read & write together (protocol violation): write executes, read is ignored, no readdatavalid.
- No outstanding-read limit: the pipeline is fixed-depth and readdatavalid is never backpressured.
- readdata holds its last value when readdatavalid=0.
- Stall: the slave never deasserts waitrequest while lwren stays high. The fill path bounds lwren bursts to one image line.

Optional Feature:
- Macro: REF_FRAME_SLAVE_STATS_EN.
- Defined: adds outputs rd_cnt[15:0], wr_cnt[15:0] and stall_cnt[15:0].
  - rd_cnt / wr_cnt count accepted Avalon reads / writes, including out-of-range ones.
  - stall_cnt counts cycles with waitrequest=1.
  - All three saturate at 16'hFFFF and are cleared by rst.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mpeg_avalon_pkg:
  - AV_ADDR_W=32, AV_DATA_W=8.
  - Default BASE constant, shared with motionestimator instantiation.
  - Pixel typedef px_t (8-bit).
- Sub-module ref_rd_pipe:
  - Parameterised RD_LAT shift register of {valid, data[7:0]}.
  - Synchronous clear on rst.
  - Outputs the final stage.

Test Plan:
- Write addr=BASE+5 data=8'hA7, then read BASE+5 -> readdatavalid exactly 2 cycles after acceptance, readdata=8'hA7; waitrequest=0 throughout.
- Burst reads BASE+0..BASE+3 on consecutive cycles after preloading 8'h10..8'h13 -> four consecutive readdatavalid pulses with 10,11,12,13, in order.
- lwren=1 (laddr=9, ldata=8'h3C) for 3 cycles while read of BASE+9 is asserted -> waitrequest=1 for 3 cycles; read accepted on the 4th cycle; readdata=8'h3C.
- Read addr=BASE-1 and addr=BASE+4096 -> readdatavalid pulses with readdata=8'h00; write to BASE+4096 leaves mem[0] unchanged.
- Accept reads at BASE+1, BASE+2, assert rst the next cycle -> no readdatavalid afterwards; readdata=0; the memory byte at BASE+1 is still readable after reset with its prior value.
- STATS_EN build: 3 reads, 2 writes, 4 stall cycles -> rd_cnt=3, wr_cnt=2, stall_cnt=4; rst clears all to 0.
